// File: rtl/lpc_pkg.sv
// Shared widths and frame_normalize controller state encoding.
package lpc_pkg;
  localparam int SAMPLE_W = 16;
  localparam int SHIFT_W  = 4;

  localparam logic [1:0] ST_FILL      = 2'd0;
  localparam logic [1:0] ST_WAIT_PEAK = 2'd1;
  localparam logic [1:0] ST_CALC      = 2'd2;
  localparam logic [1:0] ST_DRAIN     = 2'd3;
endpackage

// File: rtl/frame_ram.sv
// Frame buffer: one write port, one read port with a registered, enabled read.
module frame_ram
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int AW        = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic signed [SAMPLE_W-1:0] wdata,
  input  logic                       re,
  input  logic [AW-1:0]              raddr,
  output logic signed [SAMPLE_W-1:0] rdata
);

  logic signed [SAMPLE_W-1:0] mem [FRAME_LEN];

  // rdata only moves on re, so it doubles as the first drain pipeline stage
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_normalize.sv
// Buffers one frame, derives a left shift from the upstream peak, then
// replays the frame shifted and saturated with ready/valid backpressure.
module frame_normalize
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int AW        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic                       v,
  input  logic                       last,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] peak,
  input  logic                       peak_v,
  output logic signed [SAMPLE_W-1:0] y,
  output logic                       yv,
  input  logic                       y_ready,
  output logic                       ylast,
  output logic [SHIFT_W-1:0]         shift
);

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [1:0]                 state;
  logic [AW-1:0]              wr_ptr;
  logic [AW:0]                rd_ptr;
  logic [AW:0]                len;
  logic [AW:0]                rd_idx;
  logic signed [SAMPLE_W-1:0] peak_q;
  logic signed [SAMPLE_W-1:0] rdata_p1;
  logic                       vld_p1;
  logic                       last_p1;
  logic                       accept;
  logic                       out_en;
  logic                       re;

  function automatic logic [SHIFT_W-1:0] lzc15(input logic signed [SAMPLE_W-1:0] p);
    logic [SHIFT_W-1:0] n;
    n = '0;
    if (p > 0) begin
      for (int i = 0; i < SAMPLE_W - 1; i++)
        if (p[i]) n = SHIFT_W'(SAMPLE_W - 2 - i);
    end
    return n;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat_shl(input logic signed [SAMPLE_W-1:0] d,
                                                         input logic [SHIFT_W-1:0] s);
    logic signed [2*SAMPLE_W-1:0] t;
    t = {{SAMPLE_W{d[SAMPLE_W-1]}}, d};
    t = t <<< s;
    if (t[2*SAMPLE_W-1:SAMPLE_W-1] == '0 || t[2*SAMPLE_W-1:SAMPLE_W-1] == '1)
      return t[SAMPLE_W-1:0];
    return t[2*SAMPLE_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  assign in_ready = (state == ST_FILL);
  assign accept   = in_ready && v;
  assign out_en   = !yv || y_ready;
  assign rd_idx   = (state == ST_CALC) ? '0 : rd_ptr;
  assign re       = (state == ST_CALC) ||
                    (state == ST_DRAIN && rd_ptr < len && (!vld_p1 || out_en));

  frame_ram #(.FRAME_LEN(FRAME_LEN), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (x),
    .re    (re),
    .raddr (rd_idx[AW-1:0]),
    .rdata (rdata_p1)
  );

  // peak is only sampled, never cleared: the upstream detector owns it
  always_ff @(posedge clk) begin
    if (state == ST_WAIT_PEAK && peak_v) peak_q <= peak;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_FILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len     <= '0;
      shift   <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      y       <= '0;
      yv      <= 1'b0;
      ylast   <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (last || (&wr_ptr)) begin
              len    <= {1'b0, wr_ptr} + ONE;
              wr_ptr <= '0;
              state  <= ST_WAIT_PEAK;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ST_WAIT_PEAK: if (peak_v) state <= ST_CALC;
        ST_CALC: begin
          shift <= lzc15(peak_q);
          state <= ST_DRAIN;
        end
        default: if (yv && y_ready && ylast) state <= ST_FILL;
      endcase

      // p1: RAM read register; holds its sample while the output stage is stalled
      if (re) begin
        rd_ptr  <= rd_idx + ONE;
        vld_p1  <= 1'b1;
        last_p1 <= (rd_idx + ONE == len);
      end else if (out_en) begin
        vld_p1  <= 1'b0;
      end

      // p2: output register, the skid point for y_ready
      if (out_en) begin
        yv    <= vld_p1;
        ylast <= vld_p1 && last_p1;
        if (vld_p1) y <= sat_shl(rdata_p1, shift);
      end
    end
  end

endmodule

// File: tb/tb_frame_normalize.sv
// Directed bench for frame_normalize: vector table plus reset, full-frame and backpressure sequences.
module tb_frame_normalize;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [15:0] x = '0;
  logic signed [15:0] peak = '0;
  logic v = 1'b0, last = 1'b0, peak_v = 1'b0, y_ready = 1'b0;
  logic sel = 1'b0;

  logic in_ready_a, yv_a, ylast_a, in_ready_b, yv_b, ylast_b;
  logic signed [15:0] y_a, y_b;
  logic [3:0] shift_a, shift_b;

  frame_normalize #(.FRAME_LEN(256), .AW(8)) dut_a (
    .clk(clk), .rst(rst), .x(x), .v(v), .last(last), .in_ready(in_ready_a),
    .peak(peak), .peak_v(peak_v), .y(y_a), .yv(yv_a), .y_ready(y_ready),
    .ylast(ylast_a), .shift(shift_a)
  );

  frame_normalize #(.FRAME_LEN(16), .AW(4)) dut_b (
    .clk(clk), .rst(rst), .x(x), .v(v), .last(last), .in_ready(in_ready_b),
    .peak(peak), .peak_v(peak_v), .y(y_b), .yv(yv_b), .y_ready(y_ready),
    .ylast(ylast_b), .shift(shift_b)
  );

  logic in_ready_m, yv_m, ylast_m;
  logic signed [15:0] y_m;
  logic [3:0] shift_m;
  assign in_ready_m = sel ? in_ready_b : in_ready_a;
  assign yv_m       = sel ? yv_b : yv_a;
  assign ylast_m    = sel ? ylast_b : ylast_a;
  assign y_m        = sel ? y_b : y_a;
  assign shift_m    = sel ? shift_b : shift_a;

  typedef struct packed {
    int n;
    int pk;
    int sh;
    logic [3:0][15:0] xs;
    logic [3:0][15:0] ys;
  } vec_t;

  localparam int NV = 11;
  vec_t tab [NV];

  int n_cmp = 0;
  int n_bad = 0;
  int txq [$];
  int got_y [$];
  int got_last [$];
  int first_k;
  int sh_at;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int n, int pk, int sh, int x0, int x1, int x2, int x3,
                              int y0, int y1, int y2, int y3);
    vec_t t;
    t.n = n; t.pk = pk; t.sh = sh;
    t.xs[0] = 16'(x0); t.xs[1] = 16'(x1); t.xs[2] = 16'(x2); t.xs[3] = 16'(x3);
    t.ys[0] = 16'(y0); t.ys[1] = 16'(y1); t.ys[2] = 16'(y2); t.ys[3] = 16'(y3);
    return t;
  endfunction

  function automatic int nrm(int xv, int s);
    int t;
    t = xv * (1 << s);
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return t;
  endfunction

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("reset_yv", yv_m, 0);
    check("reset_ylast", ylast_m, 0);
    check("reset_shift", shift_m, 0);
    check("reset_y", y_m, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("reset_in_ready", in_ready_m, 1);
  endtask

  task automatic send_frame(input bit with_last);
    bit stall;
    stall = 1'b0;
    for (int i = 0; i < txq.size(); i++) begin
      x = 16'(txq[i]);
      v = 1'b1;
      last = with_last && (i == txq.size() - 1);
      if (!in_ready_m) stall = 1'b1;
      @(posedge clk); #1;
    end
    v = 1'b0;
    last = 1'b0;
    check("fill_in_ready", stall, 0);
    check("closed_in_ready", in_ready_m, 0);
  endtask

  task automatic wait_and_peak(input int p);
    bit busy;
    busy = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (in_ready_m || yv_m) busy = 1'b1;
    end
    check("wait_peak_idle", busy, 0);
    peak = 16'(p);
    peak_v = 1'b1;
    @(posedge clk); #1;
    peak_v = 1'b0;
    peak = 16'(-7);
  endtask

  task automatic collect(input int n, input bit rnd, input bit poke);
    int k, hy, hl;
    bit stab, ir, held;
    k = 0; hy = 0; hl = 0;
    stab = 1'b0; ir = 1'b0; held = 1'b0;
    got_y.delete();
    got_last.delete();
    first_k = -1;
    sh_at = -1;
    while (got_y.size() < n && k < 4000) begin
      y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        v = 1'b1;
        x = 16'sd12345;
      end
      if (in_ready_m) ir = 1'b1;
      if (held && (!yv_m || int'(y_m) != hy || int'(ylast_m) != hl)) stab = 1'b1;
      if (yv_m && first_k < 0) begin
        first_k = k;
        sh_at = int'(shift_m);
      end
      held = 1'b0;
      if (yv_m && y_ready) begin
        got_y.push_back(int'(y_m));
        got_last.push_back(int'(ylast_m));
        if (got_y.size() == n) v = 1'b0;
      end else if (yv_m) begin
        held = 1'b1;
        hy = int'(y_m);
        hl = int'(ylast_m);
      end
      @(posedge clk); #1;
      k++;
    end
    v = 1'b0;
    y_ready = 1'b0;
    check("drain_count", got_y.size(), n);
    check("first_yv_latency", first_k, 2);
    check("in_ready_drain", ir, 0);
    if (rnd) check("stall_stable", stab, 0);
    check("back_to_fill", in_ready_m, 1);
    check("yv_after_frame", yv_m, 0);
  endtask

  task automatic check_outputs(input string tag, input int sh);
    check({tag, "_shift"}, sh_at, sh);
    for (int j = 0; j < got_y.size(); j++) begin
      check($sformatf("%s_y%0d", tag, j), got_y[j], nrm(txq[j], sh));
      check($sformatf("%s_last%0d", tag, j), got_last[j], (j == txq.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t t;
    t = tab[i];
    txq.delete();
    for (int j = 0; j < t.n; j++) txq.push_back(int'($signed(t.xs[j])));
    send_frame(1'b1);
    wait_and_peak(t.pk);
    collect(t.n, (i % 2) == 1, (i % 3) == 0);
    check($sformatf("v%0d_shift", i), sh_at, t.sh);
    for (int j = 0; j < got_y.size(); j++) begin
      check($sformatf("v%0d_y%0d", i, j), got_y[j], int'($signed(t.ys[j])));
      check($sformatf("v%0d_last%0d", i, j), got_last[j], (j == t.n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tab[0]  = mk(4, 200,   7, 100, -50, 200, 7,        12800, -6400, 25600, 896);
    tab[1]  = mk(2, 1000,  5, -30000, 1000, 0, 0,      -32768, 32000, 0, 0);
    tab[2]  = mk(3, 0,     0, 0, 0, 0, 0,              0, 0, 0, 0);
    tab[3]  = mk(3, 0,     0, -5, -32768, -1, 0,       -5, -32768, -1, 0);
    tab[4]  = mk(3, -3,    0, -100, -2, -32767, 0,     -100, -2, -32767, 0);
    tab[5]  = mk(3, 1,    14, 1, -1, 16383, 0,         16384, -16384, 32767, 0);
    tab[6]  = mk(3, 16384, 0, 16384, -16384, 5, 0,     16384, -16384, 5, 0);
    tab[7]  = mk(4, 32767, 0, 32767, -32768, 3, -3,    32767, -32768, 3, -3);
    tab[8]  = mk(2, 3,    13, 3, -4, 0, 0,             24576, -32768, 0, 0);
    tab[9]  = mk(1, 7,    12, 7, 0, 0, 0,              28672, 0, 0, 0);
    tab[10] = mk(4, 2000,  4, 2000, -2000, -3000, 100, 32000, -32000, -32768, 1600);

    do_reset();
    for (int i = 0; i < NV; i++) run_vec(i);

    // Full 256-sample frame closing without last, random backpressure, v poked during drain
    txq.delete();
    for (int j = 0; j < 256; j++) txq.push_back(int'($urandom_range(0, 4000)) - 2000);
    send_frame(1'b0);
    wait_and_peak(300);
    collect(256, 1'b1, 1'b1);
    check_outputs("full256", 6);

    // Reset while a stalled drain is in flight, then a frame starting on the first edge
    txq.delete();
    txq.push_back(100); txq.push_back(-50); txq.push_back(200); txq.push_back(7);
    send_frame(1'b1);
    wait_and_peak(200);
    y_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_reset_yv", yv_m, 1);
    check("pre_reset_shift", shift_m, 7);
    do_reset();
    txq.delete();
    txq.push_back(-30000); txq.push_back(1000);
    send_frame(1'b1);
    wait_and_peak(1000);
    collect(2, 1'b0, 1'b0);
    check_outputs("post_reset", 5);

    // Small buffer: 16 samples without last close the frame
    do_reset();
    sel = 1'b1;
    txq.delete();
    for (int j = 0; j < 16; j++) txq.push_back(j * 100 - 700);
    send_frame(1'b0);
    wait_and_peak(800);
    collect(16, 1'b1, 1'b0);
    check_outputs("len16", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
